sigmoid_gather_1x8: RTL and testbench

SIGMOID_GATHER_1X8 -- requirements
Module: sigmoid_gather_1x8

---
 rtl/rnn_pkg.sv | 18 +
 rtl/sigmoid_gather_1x8.sv | 162 ++++++++++++++++
 tb/tb_sigmoid_gather_1x8.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rnn_pkg.sv
// Shared definitions for the sigmoid/RNN datapath blocks.
package rnn_pkg;

    // Gather geometry defaults: eight lanes of IEEE-754 single precision.
    localparam int unsigned LANES_DEF = 8;
    localparam int unsigned DW_DEF    = 32;

    // 1.0f in IEEE-754 single precision.
    localparam logic [31:0] ONE_F32 = 32'h3f800000;

    // Gather controller states: GATHER accepts lane results, HOLD waits
    // for the output register to drain before releasing the full bank.
    typedef enum logic {
        GATHER = 1'b0,
        HOLD   = 1'b1
    } gather_state_t;

endpackage : rnn_pkg

// File: rtl/sigmoid_gather_1x8.sv
// Gathers independent per-lane sigmoid results into one LANES-wide vector,
// with a one-entry output register and sticky duplicate/drop error flags.
module sigmoid_gather_1x8
    import rnn_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LANES-1:0]     lane_valid,
    input  logic [DW-1:0]        lane_data [LANES],
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data [LANES],
    output logic                 err_dup,
    output logic                 err_drop,
    output logic [15:0]          vec_cnt
);

    gather_state_t          r_state;
    gather_state_t          w_state_nxt;

    logic [LANES-1:0]       r_mask;
    logic [LANES-1:0]       w_mask_nxt;
    logic [DW-1:0]          r_bank [LANES];
    logic [DW-1:0]          w_merged [LANES];

    logic                   r_out_valid;
    logic [DW-1:0]          r_out_data [LANES];
    logic                   r_err_dup;
    logic                   r_err_drop;
    logic [15:0]            r_vec_cnt;

    logic                   w_gathering;
    logic [LANES-1:0]       w_cap;
    logic                   w_dup_hit;
    logic                   w_drop_hit;
    logic                   w_complete;
    logic                   w_accept;
    logic                   w_load;

    // Lane capture qualification and error detection for this cycle.
    always_comb begin
        w_gathering = (r_state == GATHER);
        w_cap       = lane_valid & ~r_mask & {LANES{w_gathering}};
        w_dup_hit   = w_gathering & (|(lane_valid & r_mask));
        w_drop_hit  = ~w_gathering & (|lane_valid);
        w_complete  = w_gathering & (&(r_mask | w_cap));
        w_accept    = r_out_valid & out_ready;
    end

    // Bank contents including this cycle's captures (what a load would see).
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            w_merged[i] = w_cap[i] ? lane_data[i] : r_bank[i];
        end
    end

    // Next-state, output-register load and mask update decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_mask_nxt  = r_mask | w_cap;
        case (r_state)
            GATHER: begin
                if (w_complete) begin
                    // Output slot free now, or being drained on this edge.
                    if (!r_out_valid || out_ready) begin
                        w_load     = 1'b1;
                        w_mask_nxt = '0;
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_mask_nxt  = '0;
                    w_state_nxt = GATHER;
                end
            end
            default: begin
                w_state_nxt = GATHER;
                w_mask_nxt  = '0;
            end
        endcase
    end

    // Controller state and capture mask registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= GATHER;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    // Gather bank: lanes written as they are captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                r_bank[i] <= w_merged[i];
            end
        end
    end

    // One-entry output register; holds data stable until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                r_out_data[i] <= '0;
            end
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                for (int unsigned i = 0; i < LANES; i++) begin
                    r_out_data[i] <= w_merged[i];
                end
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Accepted-vector counter, wrapping modulo 2^16.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec_cnt <= '0;
        end else if (w_accept) begin
            r_vec_cnt <= r_vec_cnt + 16'd1;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_dup  <= 1'b0;
            r_err_drop <= 1'b0;
        end else begin
            r_err_dup  <= r_err_dup  | w_dup_hit;
            r_err_drop <= r_err_drop | w_drop_hit;
        end
    end

    assign in_ready  = w_gathering;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign err_dup   = r_err_dup;
    assign err_drop  = r_err_drop;
    assign vec_cnt   = r_vec_cnt;

endmodule : sigmoid_gather_1x8

// File: tb/tb_sigmoid_gather_1x8.sv
// Self-checking bench for sigmoid_gather_1x8: directed table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_sigmoid_gather_1x8;
    import rnn_pkg::*;

    localparam int L = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  lane_valid;
    logic [31:0] lane_data [L];
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data [L];
    logic        err_dup;
    logic        err_drop;
    logic [15:0] vec_cnt;

    int n_vec = 0;
    int n_err = 0;

    sigmoid_gather_1x8 #(.LANES(8), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .lane_valid(lane_valid),
        .lane_data (lane_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_dup   (err_dup),
        .err_drop  (err_drop),
        .vec_cnt   (vec_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a lane slot array, "holding a finished vector"
    // flag, and a single output slot.
    logic [31:0] m_bank [L];
    logic [31:0] m_out  [L];
    logic [7:0]  m_mask;
    bit          m_hold, m_ov, m_dup, m_drop;
    logic [15:0] m_cnt;

    task automatic model_edge();
        bit acc;
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                m_bank[i] = '0;
                m_out[i]  = '0;
            end
            m_mask = '0; m_hold = 0; m_ov = 0; m_dup = 0; m_drop = 0; m_cnt = '0;
            return;
        end
        acc = m_ov && out_ready;
        if (acc) m_cnt = m_cnt + 16'd1;
        if (!m_hold) begin
            for (int i = 0; i < L; i++) begin
                if (lane_valid[i]) begin
                    if (m_mask[i]) m_dup = 1;
                    else begin
                        m_bank[i] = lane_data[i];
                        m_mask[i] = 1'b1;
                    end
                end
            end
            if (m_mask == 8'hFF) begin
                if (!m_ov || acc) begin
                    m_out  = m_bank;
                    m_ov   = 1;
                    m_mask = '0;
                end else begin
                    m_hold = 1;
                end
            end else if (acc) begin
                m_ov = 0;
            end
        end else begin
            if (lane_valid != 8'h00) m_drop = 1;
            if (acc) begin
                m_out  = m_bank;
                m_mask = '0;
                m_hold = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] @%0t: got %0h expected %0h", name, idx, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("in_ready", 0, 64'(in_ready), 64'(!m_hold));
        chk("out_valid", 0, 64'(out_valid), 64'(m_ov));
        chk("vec_cnt", 0, 64'(vec_cnt), 64'(m_cnt));
        chk("err_dup", 0, 64'(err_dup), 64'(m_dup));
        chk("err_drop", 0, 64'(err_drop), 64'(m_drop));
        for (int i = 0; i < L; i++) chk("out_data", i, 64'(out_data[i]), 64'(m_out[i]));
    endtask

    // One clock: drive inputs, clock edge, advance model, sample 1 time unit later.
    task automatic step(input logic r, input logic [7:0] v, input logic [31:0] base,
                        input logic ordy, input bit rnd);
        rst        = r;
        lane_valid = v;
        out_ready  = ordy;
        for (int i = 0; i < L; i++) lane_data[i] = rnd ? $urandom : base + 32'(i);
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        logic        r;
        logic [7:0]  lv;
        logic [31:0] base;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [15:0] e_cnt;
        logic        chk_data;
    } row_t;

    row_t tbl [17];

    initial begin
        logic [31:0] exp_d;
        bit          seen_ffff;

        // Directed table: reset, single-cycle gather, staggered gather,
        // held output followed by reset mid-gather, then recovery.
        tbl[0]  = '{1'b1, 8'hFF, 32'h0,        1'b1, 1'b0, 1'b1, 16'd0, 1'b0};
        tbl[1]  = '{1'b0, 8'hFF, 32'h3f000000, 1'b1, 1'b1, 1'b1, 16'd0, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 1'b1, 16'd1, 1'b0};
        for (int k = 0; k < 7; k++)
            tbl[3+k] = '{1'b0, 8'(1 << k), 32'h40400000, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0};
        tbl[10] = '{1'b0, 8'h80, 32'h40400000, 1'b1, 1'b1, 1'b1, 16'd1, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 1'b1, 16'd2, 1'b0};
        tbl[12] = '{1'b0, 8'hFF, ONE_F32,      1'b0, 1'b1, 1'b1, 16'd2, 1'b1};
        tbl[13] = '{1'b0, 8'h0F, 32'h40000000, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0};
        tbl[14] = '{1'b1, 8'hF0, 32'h55550000, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0};
        tbl[15] = '{1'b0, 8'hFF, 32'h3e000000, 1'b1, 1'b1, 1'b1, 16'd0, 1'b1};
        tbl[16] = '{1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 1'b1, 16'd1, 1'b0};

        rst = 1'b1; lane_valid = '0; out_ready = 1'b0;
        for (int i = 0; i < L; i++) lane_data[i] = '0;
        for (int i = 0; i < L; i++) begin m_bank[i] = '0; m_out[i] = '0; end
        m_mask = '0; m_hold = 0; m_ov = 0; m_dup = 0; m_drop = 0; m_cnt = '0;

        for (int n = 0; n < 17; n++) begin
            step(tbl[n].r, tbl[n].lv, tbl[n].base, tbl[n].ordy, 0);
            chk("tbl_out_valid", n, 64'(out_valid), 64'(tbl[n].e_ov));
            chk("tbl_in_ready", n, 64'(in_ready), 64'(tbl[n].e_ir));
            chk("tbl_vec_cnt", n, 64'(vec_cnt), 64'(tbl[n].e_cnt));
            chk("tbl_flags", n, 64'({err_dup, err_drop}), 64'(0));
            if (tbl[n].chk_data) begin
                for (int i = 0; i < L; i++)
                    chk("tbl_out_data", n * 8 + i, 64'(out_data[i]), 64'(tbl[n].base + 32'(i)));
            end
        end

        // Duplicate strobe on lane 3: first value kept, err_dup set.
        step(1'b1, 8'h00, 32'h0, 1'b1, 0);
        step(1'b0, 8'h08, 32'hAAAA0000, 1'b1, 0);
        step(1'b0, 8'h08, 32'hBBBB0000, 1'b1, 0);
        chk("dup_flag", 0, 64'(err_dup), 64'(1));
        step(1'b0, 8'hF7, 32'hCCCC0000, 1'b1, 0);
        chk("dup_ov", 0, 64'(out_valid), 64'(1));
        chk("dup_lane3", 0, 64'(out_data[3]), 64'(32'hAAAA0003));
        chk("dup_lane0", 0, 64'(out_data[0]), 64'(32'hCCCC0000));
        chk("dup_drop", 0, 64'(err_drop), 64'(0));

        // Back-pressure: two complete gathers with out_ready low -> HOLD.
        step(1'b1, 8'h00, 32'h0, 1'b0, 0);
        step(1'b0, 8'hFF, 32'h10000000, 1'b0, 0);
        chk("hold_ov1", 0, 64'(out_valid), 64'(1));
        step(1'b0, 8'hFF, 32'h20000000, 1'b0, 0);
        chk("hold_ir", 0, 64'(in_ready), 64'(0));
        step(1'b0, 8'h01, 32'h30000000, 1'b0, 0);
        chk("hold_drop", 0, 64'(err_drop), 64'(1));
        chk("hold_ir2", 0, 64'(in_ready), 64'(0));
        for (int i = 0; i < L; i++)
            chk("hold_stable", i, 64'(out_data[i]), 64'(32'h10000000 + 32'(i)));
        step(1'b0, 8'h00, 32'h0, 1'b1, 0);
        chk("hold_rel_ov", 0, 64'(out_valid), 64'(1));
        chk("hold_rel_ir", 0, 64'(in_ready), 64'(1));
        chk("hold_rel_cnt", 0, 64'(vec_cnt), 64'(1));
        for (int i = 0; i < L; i++)
            chk("hold_second", i, 64'(out_data[i]), 64'(32'h20000000 + 32'(i)));
        step(1'b0, 8'h00, 32'h0, 1'b1, 0);
        chk("hold_drain_ov", 0, 64'(out_valid), 64'(0));
        chk("hold_drain_cnt", 0, 64'(vec_cnt), 64'(2));

        // Throughput: 100 full gathers back to back with out_ready high.
        step(1'b1, 8'h00, 32'h0, 1'b1, 0);
        for (int k = 1; k <= 100; k++) begin
            step(1'b0, 8'hFF, 32'h0, 1'b1, 1);
            chk("tput_ov", k, 64'(out_valid), 64'(1));
            chk("tput_cnt", k, 64'(vec_cnt), 64'(k - 1));
        end
        step(1'b0, 8'h00, 32'h0, 1'b1, 0);
        chk("tput_total", 0, 64'(vec_cnt), 64'(100));

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] v;
            v = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom) & 8'($urandom);
            step(($urandom_range(0, 149) == 0), v, 32'h0, ($urandom_range(0, 3) != 0), 1);
        end

        // Counter wrap: stream full vectors until vec_cnt passes 0xFFFF.
        step(1'b1, 8'h00, 32'h0, 1'b1, 0);
        seen_ffff = 0;
        for (int k = 1; k <= 65538; k++) begin
            step(1'b0, 8'hFF, 32'h0, 1'b1, 1);
            if (k == 65536) begin
                chk("wrap_ffff", 0, 64'(vec_cnt), 64'(16'hFFFF));
                seen_ffff = (vec_cnt == 16'hFFFF);
            end
            if (k == 65537) chk("wrap_zero", 0, 64'(vec_cnt), 64'(0));
        end
        chk("wrap_seen", 0, 64'(seen_ffff), 64'(1));

        // Reset with a partial gather and a valid output pending.
        step(1'b0, 8'h00, 32'h0, 1'b0, 0);
        step(1'b0, 8'h0F, 32'h60000000, 1'b0, 0);
        chk("rst_pre_ov", 0, 64'(out_valid), 64'(1));
        step(1'b1, 8'hFF, 32'h70000000, 1'b0, 0);
        chk("rst_ov", 0, 64'(out_valid), 64'(0));
        chk("rst_ir", 0, 64'(in_ready), 64'(1));
        chk("rst_flags", 0, 64'({err_dup, err_drop}), 64'(0));
        chk("rst_cnt", 0, 64'(vec_cnt), 64'(0));
        step(1'b0, 8'hFF, 32'h3d000000, 1'b1, 0);
        for (int i = 0; i < L; i++) begin
            exp_d = 32'h3d000000 + 32'(i);
            chk("rst_regather", i, 64'(out_data[i]), 64'(exp_d));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sigmoid_gather_1x8
